// File: rtl/div_unit.sv
// div_unit: multi-cycle radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// One operation in flight; valid/ready request in, valid/ready response out.
// Optional build macro: DIV_EARLY_OUT_EN (|dividend| < |divisor| completes at accept).
module div_unit #(
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [4:0]        op_i,
  input  logic [DATA_W-1:0] rs1_i,
  input  logic [DATA_W-1:0] rs2_i,
  input  logic [4:0]        rd_i,
  input  logic              flush_i,
  output logic              resp_valid_o,
  input  logic              resp_ready_i,
  output logic [DATA_W-1:0] result_o,
  output logic [4:0]        rd_o
);

  localparam int CNT_W = $clog2(DATA_W);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [DATA_W-1:0]   dvd_q;
  logic [DATA_W-1:0]   dsr_q;
  logic [DATA_W-1:0]   quot_q;
  logic [DATA_W-1:0]   rem_q;
  logic                is_rem_q;
  logic                quo_neg_q;
  logic                rem_neg_q;

  logic                is_signed;
  logic                is_rem;
  logic                sign1;
  logic                sign2;
  logic [DATA_W-1:0]   mag1;
  logic [DATA_W-1:0]   mag2;
  logic                div_zero;
  logic                ovf;
  logic                early;
  logic                special;
  logic [DATA_W-1:0]   spec_result;

  logic [DATA_W:0]     shifted;
  logic [DATA_W:0]     diff;
  logic                ge;
  logic [DATA_W-1:0]   rem_next;
  logic [DATA_W-1:0]   quot_next;
  logic [DATA_W-1:0]   fixed_result;

  logic                unused_op_bits;
  assign unused_op_bits = ^op_i[4:2];

  // Accept-time decode: operand magnitudes and the cases that skip iteration
  always_comb begin
    is_signed = ~op_i[0];
    is_rem    = op_i[1];
    sign1     = is_signed & rs1_i[DATA_W-1];
    sign2     = is_signed & rs2_i[DATA_W-1];
    mag1      = sign1 ? -rs1_i : rs1_i;
    mag2      = sign2 ? -rs2_i : rs2_i;
    div_zero  = (rs2_i == '0);
    ovf       = is_signed && (rs1_i == {1'b1, {(DATA_W-1){1'b0}}}) && (rs2_i == '1);
`ifdef DIV_EARLY_OUT_EN
    early     = !div_zero && (mag1 < mag2);
`else
    early     = 1'b0;
`endif
    special   = div_zero | ovf | early;
    if (div_zero)
      spec_result = is_rem ? rs1_i : '1;
    else if (ovf)
      spec_result = is_rem ? '0 : {1'b1, {(DATA_W-1){1'b0}}};
    else
      spec_result = is_rem ? rs1_i : '0;
  end

  // One restoring-division step plus sign fix-up of the final step's values
  always_comb begin
    // remainder is widened by one bit so a divisor above 2^(W-1) cannot overflow the shift
    shifted      = {rem_q, dvd_q[DATA_W-1]};
    diff         = shifted - {1'b0, dsr_q};
    ge           = ~diff[DATA_W];
    rem_next     = ge ? diff[DATA_W-1:0] : shifted[DATA_W-1:0];
    quot_next    = {quot_q[DATA_W-2:0], ge};
    if (is_rem_q)
      fixed_result = rem_neg_q ? -rem_next : rem_next;
    else
      fixed_result = quo_neg_q ? -quot_next : quot_next;
  end

  // Control FSM with registered handshake outputs and datapath registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state        <= IDLE;
      cnt          <= '0;
      dvd_q        <= '0;
      dsr_q        <= '0;
      quot_q       <= '0;
      rem_q        <= '0;
      is_rem_q     <= 1'b0;
      quo_neg_q    <= 1'b0;
      rem_neg_q    <= 1'b0;
      req_ready_o  <= 1'b1;
      resp_valid_o <= 1'b0;
      result_o     <= '0;
      rd_o         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!flush_i && req_valid_i && req_ready_o) begin
            is_rem_q    <= is_rem;
            quo_neg_q   <= sign1 ^ sign2;
            rem_neg_q   <= sign1;
            dvd_q       <= mag1;
            dsr_q       <= mag2;
            quot_q      <= '0;
            rem_q       <= '0;
            rd_o        <= rd_i;
            req_ready_o <= 1'b0;
            if (special) begin
              result_o     <= spec_result;
              resp_valid_o <= 1'b1;
              state        <= DONE;
            end else begin
              cnt   <= CNT_W'(DATA_W-1);
              state <= CALC;
            end
          end
        end
        CALC: begin
          if (flush_i) begin
            req_ready_o <= 1'b1;
            state       <= IDLE;
          end else begin
            dvd_q  <= dvd_q << 1;
            quot_q <= quot_next;
            rem_q  <= rem_next;
            cnt    <= cnt - 1'b1;
            if (cnt == '0) begin
              result_o     <= fixed_result;
              resp_valid_o <= 1'b1;
              state        <= DONE;
            end
          end
        end
        DONE: begin
          if (flush_i || resp_ready_i) begin
            resp_valid_o <= 1'b0;
            req_ready_o  <= 1'b1;
            state        <= IDLE;
          end
        end
        default: begin
          req_ready_o  <= 1'b1;
          resp_valid_o <= 1'b0;
          state        <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed + small randomized bench for div_unit with a result scoreboard.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [4:0]  op_i;
  logic [31:0] rs1_i;
  logic [31:0] rs2_i;
  logic [4:0]  rd_i;
  logic        flush_i;
  logic        resp_valid_o;
  logic        resp_ready_i;
  logic [31:0] result_o;
  logic [4:0]  rd_o;

  int checks = 0;
  int errors = 0;

`ifdef DIV_EARLY_OUT_EN
  localparam int EARLY_LAT = 1;
`else
  localparam int EARLY_LAT = 33;
`endif

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    int          lat;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  div_unit #(.DATA_W(32)) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .op_i         (op_i),
    .rs1_i        (rs1_i),
    .rs2_i        (rs2_i),
    .rd_i         (rd_i),
    .flush_i      (flush_i),
    .resp_valid_o (resp_valid_o),
    .resp_ready_i (resp_ready_i),
    .result_o     (result_o),
    .rd_o         (rd_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference RV32M result for non-zero divisors
  function automatic logic [31:0] ref_res(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sb_;
    sa = a;
    sb_ = b;
    if (op[0] == 1'b0 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
      return op[1] ? 32'h0 : 32'h8000_0000;
    case (op)
      2'b00:   return sa / sb_;
      2'b01:   return a / b;
      2'b10:   return sa % sb_;
      default: return a % b;
    endcase
  endfunction

  function automatic int ref_lat(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] ma, mb;
    ma = (!op[0] && a[31]) ? -a : a;
    mb = (!op[0] && b[31]) ? -b : b;
    if (b == 0) return 1;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    if (ma < mb) return EARLY_LAT;
    return 33;
  endfunction

  // Drive one request at a negedge; returns after the accept edge's following negedge
  task automatic drive_req(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] rd);
    check("req_ready_before_accept", {31'b0, req_ready_o}, 32'd1);
    req_valid_i = 1'b1;
    op_i  = op;
    rs1_i = a;
    rs2_i = b;
    rd_i  = rd;
    @(negedge clk);
    req_valid_i = 1'b0;
  endtask

  // Issue, wait for the response, compare against the scoreboard, then hand-shake it off
  task automatic run_op(input string tag, input logic [4:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp_res,
                        input int exp_lat, input int hold);
    exp_t e;
    int   lat;
    sb.push_back('{res: exp_res, rd: rd, lat: exp_lat});
    drive_req(op, a, b, rd);
    lat = 1;
    while (resp_valid_o !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    e = sb.pop_front();
    check({tag, "_latency"}, lat, e.lat);
    if (resp_valid_o !== 1'b1) return;
    check({tag, "_result"}, result_o, e.res);
    check({tag, "_rd"}, {27'b0, rd_o}, {27'b0, e.rd});
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, "_hold_result"}, result_o, e.res);
      check({tag, "_hold_rd"}, {27'b0, rd_o}, {27'b0, e.rd});
      check({tag, "_hold_valid"}, {31'b0, resp_valid_o}, 32'd1);
      check({tag, "_hold_req_ready"}, {31'b0, req_ready_o}, 32'd0);
    end
    resp_ready_i = 1'b1;
    @(negedge clk);
    resp_ready_i = 1'b0;
    check({tag, "_valid_drop"}, {31'b0, resp_valid_o}, 32'd0);
    check({tag, "_req_ready_back"}, {31'b0, req_ready_o}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0]  rop;
    logic [31:0] ra, rb;
    bit          seen;

    rst_i = 1'b1;
    req_valid_i = 1'b0;
    op_i = '0;
    rs1_i = '0;
    rs2_i = '0;
    rd_i = '0;
    flush_i = 1'b0;
    resp_ready_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("reset_req_ready", {31'b0, req_ready_o}, 32'd1);
    check("reset_resp_valid", {31'b0, resp_valid_o}, 32'd0);
    check("reset_result", result_o, 32'd0);
    check("reset_rd", {27'b0, rd_o}, 32'd0);
    rst_i = 1'b0;
    @(negedge clk);

    // Unsigned and signed basics (op_i[4:2] is don't-care: 5'b11101 is DIVU)
    run_op("divu_100_7", 5'b00001, 32'd100, 32'd7, 5'd5, 32'd14, 33, 0);
    run_op("remu_100_7", 5'b00011, 32'd100, 32'd7, 5'd6, 32'd2, 33, 0);
    run_op("divu_hi_bits", 5'b11101, 32'd100, 32'd7, 5'd7, 32'd14, 33, 0);
    run_op("div_m7_2", 5'b00000, 32'hFFFF_FFF9, 32'd2, 5'd8, 32'hFFFF_FFFD, 33, 0);
    run_op("rem_m7_2", 5'b00010, 32'hFFFF_FFF9, 32'd2, 5'd9, 32'hFFFF_FFFF, 33, 0);
    run_op("div_7_m2", 5'b00000, 32'd7, 32'hFFFF_FFFE, 5'd10, 32'hFFFF_FFFD, 33, 0);
    run_op("rem_7_m2", 5'b00010, 32'd7, 32'hFFFF_FFFE, 5'd11, 32'd1, 33, 0);
    run_op("divu_big_dsr", 5'b00001, 32'hFFFF_FFFF, 32'h8000_0001, 5'd12, 32'd1, 33, 0);
    run_op("remu_big_dsr", 5'b00011, 32'hFFFF_FFFF, 32'h8000_0001, 5'd13, 32'h7FFF_FFFE, 33, 0);

    // Special cases complete at accept
    run_op("divu_5_0", 5'b00001, 32'd5, 32'd0, 5'd14, 32'hFFFF_FFFF, 1, 0);
    run_op("rem_5_0", 5'b00010, 32'd5, 32'd0, 5'd15, 32'd5, 1, 0);
    run_op("div_ovf", 5'b00000, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'h8000_0000, 1, 0);
    run_op("rem_ovf", 5'b00010, 32'h8000_0000, 32'hFFFF_FFFF, 5'd17, 32'd0, 1, 0);

    // Backpressure, then back-to-back request the cycle req_ready returns
    run_op("divu_bp", 5'b00001, 32'd1000, 32'd10, 5'd18, 32'd100, 33, 5);
    run_op("remu_b2b", 5'b00011, 32'd1000, 32'd7, 5'd19, 32'd6, 33, 0);
    run_op("div_ovf_bp", 5'b00000, 32'h8000_0000, 32'hFFFF_FFFF, 5'd20, 32'h8000_0000, 1, 3);

    // Flush in CALC: no response, ready next cycle
    drive_req(5'b00001, 32'h0000_FFFF, 32'd3, 5'd21);
    repeat (9) @(negedge clk);
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    check("flush_req_ready", {31'b0, req_ready_o}, 32'd1);
    check("flush_resp_valid", {31'b0, resp_valid_o}, 32'd0);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (resp_valid_o === 1'b1) seen = 1'b1;
    end
    check("flush_no_resp", {31'b0, seen}, 32'd0);

    // Flush in IDLE wins over a simultaneous request
    flush_i = 1'b1;
    req_valid_i = 1'b1;
    op_i = 5'b00001;
    rs1_i = 32'd8;
    rs2_i = 32'd0;
    rd_i = 5'd22;
    @(negedge clk);
    flush_i = 1'b0;
    req_valid_i = 1'b0;
    check("idle_flush_no_accept", {31'b0, resp_valid_o}, 32'd0);
    check("idle_flush_ready", {31'b0, req_ready_o}, 32'd1);
    run_op("divu_9_3", 5'b00001, 32'd9, 32'd3, 5'd23, 32'd3, 33, 0);

    // Asynchronous reset between edges mid-CALC
    drive_req(5'b00001, 32'd1234, 32'd5, 5'd24);
    repeat (5) @(negedge clk);
    #2 rst_i = 1'b1;
    #1;
    check("async_rst_valid", {31'b0, resp_valid_o}, 32'd0);
    check("async_rst_ready", {31'b0, req_ready_o}, 32'd1);
    check("async_rst_result", result_o, 32'd0);
    @(negedge clk);
    rst_i = 1'b0;
    @(negedge clk);

    // Dividend magnitude below divisor magnitude
    run_op("divu_3_10", 5'b00001, 32'd3, 32'd10, 5'd25, 32'd0, EARLY_LAT, 0);
    run_op("remu_3_10", 5'b00011, 32'd3, 32'd10, 5'd26, 32'd3, EARLY_LAT, 0);
    run_op("div_m3_10", 5'b00000, 32'hFFFF_FFFD, 32'd10, 5'd27, 32'd0, EARLY_LAT, 0);
    run_op("rem_m3_10", 5'b00010, 32'hFFFF_FFFD, 32'd10, 5'd28, 32'hFFFF_FFFD, EARLY_LAT, 0);

    // Randomized operands against the reference model
    for (int i = 0; i < 8; i++) begin
      rop = 5'($urandom_range(0, 31));
      ra = $urandom;
      rb = $urandom >> $urandom_range(0, 31);
      if (rb == 0) rb = 32'd3;
      run_op("rand", rop, ra, rb, 5'(i), ref_res(rop[1:0], ra, rb), ref_lat(rop[1:0], ra, rb), i % 2);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
